// File: rtl/ov5640_cfg_pkg.sv
// Shared types and constants for the OV5640 register-configuration sequencer.
// The retry feature in the top level is selected with the CFG_ACK_RETRY_EN macro.
package ov5640_cfg_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_CHECK,
    ST_GAP,
    ST_SWWAIT,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } cfg_entry_t;

  typedef struct packed {
    cfg_state_e  state;
    logic        last_ack;
    logic [7:0]  retry;
    logic [7:0]  retry_max;
  } cfg_dbg_t;

  localparam int         CFG_ENTRY_NUM = 3;
  localparam logic [15:0] SWRST_ADDR   = 16'h3008;
  localparam logic [7:0]  SWRST_DATA   = 8'h82;

  function automatic logic [31:0] pack_word(input logic [7:0] slave, input cfg_entry_t e);
    return {slave, e.addr, e.data};
  endfunction

endpackage

// File: rtl/ov5640_cfg_rom.sv
// Combinational register table: index -> {addr, data}, plus a last-entry flag.
// Entry 0 must stay the soft reset; the sequencer waits after it.
module ov5640_cfg_rom
  import ov5640_cfg_pkg::*;
(
  input  logic [7:0] index_i,
  output cfg_entry_t entry_o,
  output logic       last_o
);

  always_comb begin
    entry_o = '0;
    case (index_i)
      8'd0:    entry_o = '{addr: SWRST_ADDR, data: SWRST_DATA};
      8'd1:    entry_o = '{addr: 16'h3103,   data: 8'h03};
      8'd2:    entry_o = '{addr: 16'h3008,   data: 8'h02};
      default: entry_o = '0;
    endcase
  end

  assign last_o = (index_i == 8'(CFG_ENTRY_NUM - 1));

endmodule

// File: rtl/ov5640_reg_cfg.sv
// OV5640 register-configuration sequencer feeding the camera I2C write engine.
// Define CFG_ACK_RETRY_EN to retry NACKed/timed-out entries up to MAX_RETRY times.
module ov5640_reg_cfg
  import ov5640_cfg_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR        = 8'h78,
  parameter int         PWRUP_CYCLES      = 480000,
  parameter int         SWRST_WAIT_CYCLES = 120000,
  parameter int         GAP_CYCLES        = 16,
  parameter int         TIMEOUT_CYCLES    = 65535,
  parameter int         MAX_RETRY         = 3,
  parameter int         CNT_W             = 20
) (
  input  logic        camera_clk_i,
  input  logic        iic_rstn_i,
  input  logic        cfg_restart_i,
  output logic [31:0] iic_data_o,
  output logic        iic_start_o,
  input  logic        iic_end_i,
  input  logic        iic_ack_i,
  output logic [7:0]  cfg_index_o,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        cfg_err_o,
  output cfg_dbg_t    cfg_dbg_o
);

  // Engine handshake: iic_start_o is a level held high for the whole transfer.
  // iic_end_i stays high from the previous transfer until the engine restarts,
  // so a transfer completes only on end low (ARM) followed by end high (RUN).
  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic             ack_q, ack_d;
  logic             tmo_q, tmo_d;
  logic             fail;
  cfg_entry_t       rom_entry;
  logic             rom_last;

  ov5640_cfg_rom u_rom (
    .index_i (idx_q),
    .entry_o (rom_entry),
    .last_o  (rom_last)
  );

`ifdef CFG_ACK_RETRY_EN
  logic [7:0] retry_q, retry_d;
  assign fail = tmo_q | ack_q;
`else
  assign fail = tmo_q;
`endif

  always_ff @(posedge camera_clk_i or negedge iic_rstn_i) begin
    if (!iic_rstn_i) begin
      state_q <= ST_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef CFG_ACK_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
`ifdef CFG_ACK_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    ack_d   = ack_q;
    tmo_d   = tmo_q;
`ifdef CFG_ACK_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        data_d  = pack_word(SLAVE_ADDR, rom_entry);
        tmo_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_CHECK;
        end else if (!iic_end_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (iic_end_i) begin
          ack_d   = iic_ack_i;
          state_d = ST_CHECK;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        cnt_d = '0;
        if (fail) begin
`ifdef CFG_ACK_RETRY_EN
          if (retry_q < 8'(MAX_RETRY)) begin
            retry_d = retry_q + 8'd1;
            state_d = ST_GAP;
          end else begin
            state_d = ST_ERR;
          end
`else
          state_d = ST_ERR;
`endif
        end else begin
`ifdef CFG_ACK_RETRY_EN
          retry_d = '0;
`endif
          if (rom_last) begin
            state_d = ST_DONE;
          end else if (idx_q == 8'd0) begin
            state_d = ST_SWWAIT;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_SWWAIT: begin
        if (cnt_q == CNT_W'(SWRST_WAIT_CYCLES - 1)) begin
          cnt_d   = '0;
          idx_d   = idx_q + 8'd1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE, ST_ERR: begin
        cnt_d = cnt_q;
        if (cfg_restart_i) begin
          idx_d   = '0;
          cnt_d   = '0;
`ifdef CFG_ACK_RETRY_EN
          retry_d = '0;
`endif
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // Outputs decode the state register so an async reset drops start at once.
  assign iic_start_o = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign iic_data_o  = data_q;
  assign cfg_index_o = idx_q;
  assign cfg_done_o  = (state_q == ST_DONE);
  assign cfg_err_o   = (state_q == ST_ERR);
  assign cfg_busy_o  = !(cfg_done_o || cfg_err_o);

  assign cfg_dbg_o.state     = state_q;
  assign cfg_dbg_o.last_ack  = ack_q;
  assign cfg_dbg_o.retry_max = 8'(MAX_RETRY);
`ifdef CFG_ACK_RETRY_EN
  assign cfg_dbg_o.retry     = retry_q;
`else
  assign cfg_dbg_o.retry     = 8'd0;
`endif

endmodule

// File: tb/tb_ov5640_reg_cfg.sv
// Bench for ov5640_reg_cfg: randomized I2C engine model plus a table-walk reference model.
// Build with CFG_ACK_RETRY_EN defined to cover the retry variant.
module tb_ov5640_reg_cfg;
  import ov5640_cfg_pkg::*;

  localparam int PWRUP = 10;
  localparam int SWRST = 50;
  localparam int GAP   = 16;
  localparam int TMO   = 100;
  localparam int MAXR  = 2;
  localparam int N_ENT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        iic_end_i;
  logic        iic_ack_i;
  logic [31:0] iic_data_o;
  logic        iic_start_o;
  logic [7:0]  cfg_index_o;
  logic        cfg_busy_o, cfg_done_o, cfg_err_o;
  cfg_dbg_t    dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] obs_word[$];
  logic [31:0] exp_q[$];
  int          obs_low[$];
  int          obs_high[$];
  int          exp_low[$];
  int          eng_len_q[$];
  int          n_unstable = 0;
  int          eng_hold = 0;
  int          nack_idx = -1;
  int          hang_idx = -1;
  bit          exp_done, exp_err;
  int          exp_idx;

  ov5640_reg_cfg #(
    .SLAVE_ADDR        (8'h78),
    .PWRUP_CYCLES      (PWRUP),
    .SWRST_WAIT_CYCLES (SWRST),
    .GAP_CYCLES        (GAP),
    .TIMEOUT_CYCLES    (TMO),
    .MAX_RETRY         (MAXR),
    .CNT_W             (20)
  ) dut (
    .camera_clk_i  (clk),
    .iic_rstn_i    (rst_n),
    .cfg_restart_i (restart),
    .iic_data_o    (iic_data_o),
    .iic_start_o   (iic_start_o),
    .iic_end_i     (iic_end_i),
    .iic_ack_i     (iic_ack_i),
    .cfg_index_o   (cfg_index_o),
    .cfg_busy_o    (cfg_busy_o),
    .cfg_done_o    (cfg_done_o),
    .cfg_err_o     (cfg_err_o),
    .cfg_dbg_o     (dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- reference data ----------------
  function automatic logic [31:0] tb_word(input int i);
    case (i)
      0:       return 32'h78300882;
      1:       return 32'h78310303;
      2:       return 32'h78300802;
      default: return 32'h0;
    endcase
  endfunction

  // Walks the table by the sequencer's rules: which words go out, and how long
  // start is low before each one (-1 = not checked).
  task automatic build_model();
    int idx = 0;
    int low = -1;
    bit fail;
`ifdef CFG_ACK_RETRY_EN
    int retry = 0;
`endif
    exp_q.delete();
    exp_low.delete();
    exp_done = 0;
    exp_err  = 0;
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(tb_word(idx));
      exp_low.push_back(low);
`ifdef CFG_ACK_RETRY_EN
      fail = (idx == nack_idx) || (idx == hang_idx);
      if (fail && retry < MAXR) begin
        retry++;
        low = GAP + 2;
        continue;
      end
      if (!fail) retry = 0;
`else
      fail = (idx == hang_idx);
`endif
      if (fail) begin
        exp_err = 1;
        break;
      end
      if (idx == N_ENT - 1) begin
        exp_done = 1;
        break;
      end
      low = (idx == 0) ? SWRST + 2 : GAP + 2;
      idx++;
    end
    exp_idx = idx;
  endtask

  // ---------------- I2C engine model ----------------
  initial begin : engine
    int  cnt;
    int  cur_len;
    bit  cur_nack, cur_hang;
    iic_end_i = 1'b1;
    iic_ack_i = 1'b0;
    cnt = 0;
    cur_len = 0;
    cur_nack = 0;
    cur_hang = 0;
    forever begin
      @(negedge clk);
      if (!iic_start_o) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          cur_len  = $urandom_range(3, 12);
          cur_nack = (nack_idx >= 0) && (iic_data_o == tb_word(nack_idx));
          cur_hang = (hang_idx >= 0) && (iic_data_o == tb_word(hang_idx));
          eng_len_q.push_back(cur_hang ? -1 : cur_len);
        end
        cnt++;
        if (cnt == eng_hold + 1) iic_end_i = 1'b0;
        if (!cur_hang && cnt == eng_hold + 1 + cur_len) begin
          iic_end_i = 1'b1;
          iic_ack_i = cur_nack;
        end
      end
    end
  end

  // ---------------- start/data monitor ----------------
  initial begin : monitor
    bit prev = 0;
    int lo = 0;
    int hi = 0;
    forever begin
      @(negedge clk);
      if (iic_start_o) begin
        if (!prev) begin
          obs_word.push_back(iic_data_o);
          obs_low.push_back(lo);
          hi = 0;
        end else if (obs_word.size() > 0 && iic_data_o !== obs_word[$]) begin
          n_unstable++;
        end
        hi++;
      end else begin
        if (prev) begin
          obs_high.push_back(hi);
          lo = 0;
        end
        lo++;
      end
      prev = iic_start_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    obs_word.delete();
    obs_low.delete();
    obs_high.delete();
    eng_len_q.delete();
    n_unstable = 0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (cfg_done_o || cfg_err_o) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (iic_start_o !== 1'b0) $display("FAIL reset_start: got %b expected 0", iic_start_o); else n_pass++;
    n_checks++; if (iic_data_o !== 32'h0) $display("FAIL reset_data: got %h expected 0", iic_data_o); else n_pass++;
    n_checks++; if (cfg_index_o !== 8'd0) $display("FAIL reset_index: got %0d expected 0", cfg_index_o); else n_pass++;
    n_checks++; if (cfg_done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", cfg_done_o); else n_pass++;
    n_checks++; if (cfg_err_o !== 1'b0) $display("FAIL reset_err: got %b expected 0", cfg_err_o); else n_pass++;
    n_checks++; if (cfg_busy_o !== 1'b1) $display("FAIL reset_busy: got %b expected 1", cfg_busy_o); else n_pass++;
    n_checks++; if (dbg.state !== ST_PWRUP) $display("FAIL reset_state: got %0d expected %0d", dbg.state, ST_PWRUP); else n_pass++;
  endtask

  task automatic test_nominal();
    bit ok;
    int exp_h;
    eng_hold = 0; nack_idx = -1; hang_idx = -1;
    clear_obs();
    build_model();
    rst_n = 1'b1;
    // Start must not rise before the power-up delay has elapsed.
    repeat (PWRUP) @(negedge clk);
    n_checks++; if (obs_word.size() != 0) $display("FAIL pwrup_early_start: got %0d starts expected 0", obs_word.size()); else n_pass++;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL nominal_wait: got timeout expected done/err"); else n_pass++;
    n_checks++; if (obs_word.size() != exp_q.size()) $display("FAIL nominal_count: got %0d expected %0d", obs_word.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < obs_word.size()) begin
      n_checks++; if (obs_word[i] !== exp_q[i]) $display("FAIL nominal_word%0d: got %h expected %h", i, obs_word[i], exp_q[i]); else n_pass++;
      if (exp_low[i] >= 0) begin
        n_checks++; if (obs_low[i] != exp_low[i]) $display("FAIL nominal_gap%0d: got %0d expected %0d", i, obs_low[i], exp_low[i]); else n_pass++;
      end
      if (i < obs_high.size() && i < eng_len_q.size()) begin
        exp_h = (eng_len_q[i] < 0) ? TMO : eng_hold + eng_len_q[i] + 1;
        n_checks++; if (obs_high[i] != exp_h) $display("FAIL nominal_len%0d: got %0d expected %0d", i, obs_high[i], exp_h); else n_pass++;
      end
    end
    n_checks++; if (n_unstable != 0) $display("FAIL nominal_data_stable: got %0d changes expected 0", n_unstable); else n_pass++;
    n_checks++; if (cfg_done_o !== exp_done) $display("FAIL nominal_done: got %b expected %b", cfg_done_o, exp_done); else n_pass++;
    n_checks++; if (cfg_busy_o !== 1'b0) $display("FAIL nominal_busy: got %b expected 0", cfg_busy_o); else n_pass++;
    n_checks++; if (cfg_index_o !== 8'(exp_idx)) $display("FAIL nominal_index: got %0d expected %0d", cfg_index_o, exp_idx); else n_pass++;
    n_checks++; if (iic_start_o !== 1'b0) $display("FAIL nominal_start_idle: got %b expected 0", iic_start_o); else n_pass++;
  endtask

  task automatic test_end_hold();
    bit ok;
    int exp_h;
    eng_hold = 5; nack_idx = -1; hang_idx = -1;
    build_model();
    pulse_restart();
    clear_obs();
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL hold_wait: got timeout expected done/err"); else n_pass++;
    n_checks++; if (obs_word.size() != exp_q.size()) $display("FAIL hold_count: got %0d expected %0d", obs_word.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < obs_word.size()) begin
      n_checks++; if (obs_word[i] !== exp_q[i]) $display("FAIL hold_word%0d: got %h expected %h", i, obs_word[i], exp_q[i]); else n_pass++;
      if (i < obs_high.size() && i < eng_len_q.size()) begin
        exp_h = (eng_len_q[i] < 0) ? TMO : eng_hold + eng_len_q[i] + 1;
        n_checks++; if (obs_high[i] != exp_h) $display("FAIL hold_len%0d: got %0d expected %0d", i, obs_high[i], exp_h); else n_pass++;
      end
    end
    n_checks++; if (cfg_done_o !== exp_done) $display("FAIL hold_done: got %b expected %b", cfg_done_o, exp_done); else n_pass++;
  endtask

  task automatic test_nack();
    bit ok;
    eng_hold = $urandom_range(0, 3); nack_idx = 1; hang_idx = -1;
    build_model();
    pulse_restart();
    clear_obs();
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL nack_wait: got timeout expected done/err"); else n_pass++;
    n_checks++; if (obs_word.size() != exp_q.size()) $display("FAIL nack_count: got %0d expected %0d", obs_word.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < obs_word.size()) begin
      n_checks++; if (obs_word[i] !== exp_q[i]) $display("FAIL nack_word%0d: got %h expected %h", i, obs_word[i], exp_q[i]); else n_pass++;
      if (exp_low[i] >= 0) begin
        n_checks++; if (obs_low[i] != exp_low[i]) $display("FAIL nack_gap%0d: got %0d expected %0d", i, obs_low[i], exp_low[i]); else n_pass++;
      end
    end
    n_checks++; if (cfg_done_o !== exp_done) $display("FAIL nack_done: got %b expected %b", cfg_done_o, exp_done); else n_pass++;
    n_checks++; if (cfg_err_o !== exp_err) $display("FAIL nack_err: got %b expected %b", cfg_err_o, exp_err); else n_pass++;
    n_checks++; if (cfg_index_o !== 8'(exp_idx)) $display("FAIL nack_index: got %0d expected %0d", cfg_index_o, exp_idx); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    int exp_h;
    eng_hold = 0; nack_idx = -1; hang_idx = 2;
    build_model();
    pulse_restart();
    clear_obs();
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL tmo_wait: got timeout expected done/err"); else n_pass++;
    n_checks++; if (obs_word.size() != exp_q.size()) $display("FAIL tmo_count: got %0d expected %0d", obs_word.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < obs_word.size()) begin
      n_checks++; if (obs_word[i] !== exp_q[i]) $display("FAIL tmo_word%0d: got %h expected %h", i, obs_word[i], exp_q[i]); else n_pass++;
      if (i < obs_high.size() && i < eng_len_q.size()) begin
        exp_h = (eng_len_q[i] < 0) ? TMO : eng_hold + eng_len_q[i] + 1;
        n_checks++; if (obs_high[i] != exp_h) $display("FAIL tmo_len%0d: got %0d expected %0d", i, obs_high[i], exp_h); else n_pass++;
      end
    end
    n_checks++; if (cfg_err_o !== exp_err) $display("FAIL tmo_err: got %b expected %b", cfg_err_o, exp_err); else n_pass++;
    n_checks++; if (cfg_busy_o !== 1'b0) $display("FAIL tmo_busy: got %b expected 0", cfg_busy_o); else n_pass++;
    n_checks++; if (cfg_index_o !== 8'(exp_idx)) $display("FAIL tmo_index: got %0d expected %0d", cfg_index_o, exp_idx); else n_pass++;
    // Restart from ERR clears status immediately and reruns from entry 0.
    hang_idx = -1;
    build_model();
    pulse_restart();
    n_checks++; if (cfg_err_o !== 1'b0) $display("FAIL restart_err: got %b expected 0", cfg_err_o); else n_pass++;
    n_checks++; if (cfg_busy_o !== 1'b1) $display("FAIL restart_busy: got %b expected 1", cfg_busy_o); else n_pass++;
    n_checks++; if (cfg_index_o !== 8'd0) $display("FAIL restart_index: got %0d expected 0", cfg_index_o); else n_pass++;
    clear_obs();
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL rerun_wait: got timeout expected done/err"); else n_pass++;
    n_checks++; if (obs_word.size() != exp_q.size()) $display("FAIL rerun_count: got %0d expected %0d", obs_word.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < obs_word.size()) begin
      n_checks++; if (obs_word[i] !== exp_q[i]) $display("FAIL rerun_word%0d: got %h expected %h", i, obs_word[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (cfg_done_o !== exp_done) $display("FAIL rerun_done: got %b expected %b", cfg_done_o, exp_done); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    bit seen;
    eng_hold = 0; nack_idx = -1; hang_idx = -1;
    pulse_restart();
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (iic_start_o) begin
        seen = 1;
        break;
      end
    end
    n_checks++; if (!seen) $display("FAIL midrst_start_seen: got no start expected start"); else n_pass++;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (iic_start_o !== 1'b0) $display("FAIL midrst_start: got %b expected 0", iic_start_o); else n_pass++;
    n_checks++; if (iic_data_o !== 32'h0) $display("FAIL midrst_data: got %h expected 0", iic_data_o); else n_pass++;
    n_checks++; if (cfg_index_o !== 8'd0) $display("FAIL midrst_index: got %0d expected 0", cfg_index_o); else n_pass++;
    n_checks++; if (cfg_busy_o !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", cfg_busy_o); else n_pass++;
    n_checks++; if (cfg_done_o !== 1'b0 || cfg_err_o !== 1'b0) $display("FAIL midrst_status: got done=%b err=%b expected 0/0", cfg_done_o, cfg_err_o); else n_pass++;
    repeat (3) @(negedge clk);
    clear_obs();
    build_model();
    rst_n = 1'b1;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL midrst_wait: got timeout expected done/err"); else n_pass++;
    n_checks++; if (obs_word.size() != exp_q.size()) $display("FAIL midrst_count: got %0d expected %0d", obs_word.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) if (i < obs_word.size()) begin
      n_checks++; if (obs_word[i] !== exp_q[i]) $display("FAIL midrst_word%0d: got %h expected %h", i, obs_word[i], exp_q[i]); else n_pass++;
      if (exp_low[i] >= 0) begin
        n_checks++; if (obs_low[i] != exp_low[i]) $display("FAIL midrst_gap%0d: got %0d expected %0d", i, obs_low[i], exp_low[i]); else n_pass++;
      end
    end
    n_checks++; if (cfg_done_o !== exp_done) $display("FAIL midrst_done: got %b expected %b", cfg_done_o, exp_done); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_end_hold();
    test_nack();
    test_timeout();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
